lab5_mux_feeder: RTL

//  Upstream stage for the 1-bit-select 2-to-1 multiplexor (lab5com1 datapath slice).
//  - Accepts {select, data0, data1} operand vectors over a valid/ready handshake.
//  - Buffers them in a small FIFO and presents the head entry on S/D0/D1 to the mux.
//  - Captures the mux result Y into a registered output with its own valid/ready handshake.

---
 rtl/lab5_mux_feeder_pkg.sv | 19 +
 rtl/lab5_fifo.sv | 61 ++++++
 rtl/lab5_mux_feeder.sv | 83 ++++++++
 3 files changed

// File: rtl/lab5_mux_feeder_pkg.sv
// Shared definitions for the lab5 mux feeder.
//  - out_state_e : output-register FSM encoding (EMPTY = nothing held, FULL = out_y valid)
//  - VEC_W       : operand vector width {s, d0, d1} for the default WIDTH=1 slice
//  - vec_w_of()  : the same width for any WIDTH
package lab5_mux_feeder_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  localparam int DEF_WIDTH = 1;
  localparam int VEC_W     = 1 + 2*DEF_WIDTH;

  function automatic int vec_w_of(input int width);
    return 1 + 2*width;
  endfunction

endpackage

// File: rtl/lab5_fifo.sv
// Small synchronous FIFO holding {s, d0, d1} operand vectors.
//  clk, rst_n : clock / async active-low reset (pointers and count only)
//  push, wdata: write request and data; ignored while full
//  pop        : read request; ignored while empty
//  head       : entry at rd_ptr straight from storage, zero while empty
//  count      : occupancy 0..DEPTH
//  full/empty : derived from count
module lab5_fifo
  import lab5_mux_feeder_pkg::*;
#(
  parameter int VW    = VEC_W,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [VW-1:0]    wdata,
  input  logic             pop,
  output logic [VW-1:0]    head,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [VW-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0] cnt;
  logic           do_push, do_pop;

  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  // full is evaluated on current state, so a same-cycle pop never frees a slot
  assign do_push = push & ~full;
  assign do_pop  = pop  & ~empty;
  assign count   = cnt;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage is not reset: stale entries are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/lab5_mux_feeder.sv
// Upstream feeder for the external 2-to-1 mux slice.
//  clk, rst_n             : clock / async active-low reset
//  in_valid/in_ready      : operand handshake; in_ready = FIFO not full
//  in_s, in_d0, in_d1     : operand vector
//  s, d0, d1              : FIFO head driven to the mux (zero when empty)
//  y                      : combinational mux result, sampled only on a pop
//  out_valid/out_ready    : result handshake
//  out_y                  : registered mux result
//  count                  : FIFO occupancy
module lab5_mux_feeder
  import lab5_mux_feeder_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_s,
  input  logic [WIDTH-1:0] in_d0,
  input  logic [WIDTH-1:0] in_d1,
  output logic             s,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [PTR_W:0]   count
);

  localparam int VW = vec_w_of(WIDTH);

  out_state_e     state;
  logic [VW-1:0]  head;
  logic           full, empty, pop;

  // Pop whenever there is a head entry and the output register is free or
  // being drained this cycle; the FSM captures y on exactly these edges.
  assign pop = ~empty & ((state == ST_EMPTY) | out_ready);

  lab5_fifo #(.VW(VW), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata ({in_s, in_d0, in_d1}),
    .pop   (pop),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign in_ready     = ~full;
  assign {s, d0, d1}  = head;
  assign out_valid    = (state == ST_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      out_y <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (!empty) begin
            out_y <= y;
            state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (!empty) out_y <= y;
            else        state <= ST_EMPTY;  // out_y keeps last value
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule
